pow_bcd_conv: RTL and testbench

- Downstream stage of the integer power unit.
- Consumes its 32-bit two's-complement result and error flags on the one-cycle completion pulse.
- Converts magnitude to packed BCD by sequential double-dabble, one bit per cycle; emits sign and error code for the display/UART formatter.
- Holds the last converted value stable until the next conversion completes.

---
 rtl/pow_pkg.sv | 16 +
 rtl/bcd_add3.sv | 12 +
 rtl/pow_bcd_conv.sv | 124 ++++++++++++
 tb/tb_pow_bcd_conv.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pow_pkg.sv
// Shared types and constants for the power-unit BCD conversion stage.
// Imported by the converter top and its digit-adjust cell.
package pow_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_DOMAIN = 2'b01;
    localparam logic [1:0] ERR_OVF    = 2'b10;

    localparam int BCD_W = 4;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction.
// Adds 3 to a BCD digit of 5 or more so the next shift carries correctly.
module bcd_add3
    import pow_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    output logic [BCD_W-1:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/pow_bcd_conv.sv
// Sequential double-dabble converter for the power unit result.
// One magnitude bit per cycle; error results bypass conversion.
module pow_bcd_conv
    import pow_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_cflag,
    input  logic                    in_oflag,
    output logic                    busy,
    output logic                    out_valid,
    output logic [BCD_W*DIGITS-1:0] out_bcd,
    output logic                    out_neg,
    output logic [1:0]              out_err
);

    localparam int BW = BCD_W * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sign_q, sign_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [BW-1:0]   scr_q, scr_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            neg_q, neg_d;
    logic [1:0]      err_q, err_d;
    logic            vld_q, vld_d;

    logic [BW-1:0]    scr_adj;
    logic [BW-1:0]    scr_sh;
    logic [WIDTH-1:0] mag_sh;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (scr_q[g*BCD_W +: BCD_W]),
            .digit_o (scr_adj[g*BCD_W +: BCD_W])
        );
    end

    // Magnitude MSB feeds the bottom of the BCD scratch on each shift.
    assign scr_sh = {scr_adj[BW-2:0], mag_q[WIDTH-1]};
    assign mag_sh = {mag_q[WIDTH-2:0], 1'b0};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        scr_d   = scr_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        err_d   = err_q;
        vld_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = in_data[WIDTH-1];
                    mag_d  = in_data[WIDTH-1] ? -in_data : in_data;
                    scr_d  = '0;
                    cnt_d  = '0;
                    if (in_cflag || in_oflag) begin
                        err_d = in_cflag ? ERR_DOMAIN : ERR_OVF;
                        bcd_d = '0;
                        neg_d = 1'b0;
                        vld_d = 1'b1;
                    end else begin
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                scr_d = scr_sh;
                mag_d = mag_sh;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    bcd_d   = scr_sh;
                    neg_d   = sign_q;
                    err_d   = ERR_OK;
                    vld_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            err_q   <= ERR_OK;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            scr_q   <= scr_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
        end
    end

    assign busy      = (state_q == CONV);
    assign out_valid = vld_q;
    assign out_bcd   = bcd_q;
    assign out_neg   = neg_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_pow_bcd_conv.sv
// Directed bench for pow_bcd_conv: conversions, error bypass, dropped
// requests, back-to-back accept and asynchronous abort.
module tb_pow_bcd_conv;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_cflag;
    logic        in_oflag;
    logic        busy;
    logic        out_valid;
    logic [39:0] out_bcd;
    logic        out_neg;
    logic [1:0]  out_err;

    int ncmp = 0;
    int nfail = 0;

    pow_bcd_conv #(.WIDTH(32), .DIGITS(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_cflag  (in_cflag),
        .in_oflag  (in_oflag),
        .busy      (busy),
        .out_valid (out_valid),
        .out_bcd   (out_bcd),
        .out_neg   (out_neg),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives a request at the current negedge; returns at the next negedge.
    task automatic launch(input logic [31:0] d, input logic cf,
                          input logic of);
        in_data  = d;
        in_cflag = cf;
        in_oflag = of;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_cflag = 1'b0;
        in_oflag = 1'b0;
    endtask

    // Waits for completion, optionally injecting a request at cycle inj.
    task automatic wait_done(input string tag, input logic [39:0] ebcd,
                             input logic eneg, input int inj);
        int n;
        int bc;
        bit got;
        n = 0;
        bc = 0;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                got = 1;
                n = i;
                break;
            end
            if (busy) bc++;
            if (inj != 0 && i == inj) begin
                in_valid = 1'b1;
                in_data  = 32'd5;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk({tag, "_done"}, 64'(got), 64'd1);
        chk({tag, "_lat"}, 64'(n), 64'd32);
        chk({tag, "_busy"}, 64'(bc), 64'd32);
        chk({tag, "_bcd"}, 64'(out_bcd), 64'(ebcd));
        chk({tag, "_neg"}, 64'(out_neg), 64'(eneg));
        chk({tag, "_err"}, 64'(out_err), 64'd0);
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int vcnt;
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_cflag = 1'b0;
        in_oflag = 1'b0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_vld", 64'(out_valid), 64'd0);
        chk("rst_bcd", 64'(out_bcd), 64'd0);
        chk("rst_neg", 64'(out_neg), 64'd0);
        chk("rst_err", 64'(out_err), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        launch(32'd12345, 1'b0, 1'b0);
        wait_done("c12345", 40'h0000012345, 1'b0, 0);
        @(negedge clk);
        chk("c12345_pulse", 64'(out_valid), 64'd0);
        chk("c12345_hold", 64'(out_bcd), 64'h0000012345);

        launch(32'd7, 1'b1, 1'b1);
        chk("cf_vld", 64'(out_valid), 64'd1);
        chk("cf_err", 64'(out_err), 64'd1);
        chk("cf_bcd", 64'(out_bcd), 64'd0);
        chk("cf_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("cf_pulse", 64'(out_valid), 64'd0);
        chk("cf_busy2", 64'(busy), 64'd0);

        launch(32'd7, 1'b0, 1'b1);
        chk("of_vld", 64'(out_valid), 64'd1);
        chk("of_err", 64'(out_err), 64'd2);
        chk("of_busy", 64'(busy), 64'd0);
        @(negedge clk);

        launch(32'd999, 1'b0, 1'b0);
        wait_done("c999", 40'h0000000999, 1'b0, 10);
        launch(32'd42, 1'b0, 1'b0);
        chk("b2b_pulse", 64'(out_valid), 64'd0);
        chk("b2b_busy", 64'(busy), 64'd1);
        chk("b2b_hold", 64'(out_bcd), 64'h0000000999);
        wait_done("c42", 40'h0000000042, 1'b0, 0);
        @(negedge clk);

        launch(32'hFFFFFFFF, 1'b0, 1'b0);
        wait_done("cm1", 40'h0000000001, 1'b1, 0);
        @(negedge clk);

        launch(32'h80000000, 1'b0, 1'b0);
        wait_done("cmin", 40'h2147483648, 1'b1, 0);
        @(negedge clk);

        launch(32'd123, 1'b0, 1'b0);
        repeat (15) @(negedge clk);
        chk("ab_busy_pre", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("ab_busy", 64'(busy), 64'd0);
        chk("ab_bcd", 64'(out_bcd), 64'd0);
        chk("ab_neg", 64'(out_neg), 64'd0);
        chk("ab_err", 64'(out_err), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) vcnt++;
            @(negedge clk);
        end
        chk("ab_no_vld", 64'(vcnt), 64'd0);

        launch(32'd7, 1'b0, 1'b0);
        wait_done("c7", 40'h0000000007, 1'b0, 0);
        @(negedge clk);

        launch(32'd0, 1'b0, 1'b0);
        wait_done("c0", 40'h0000000000, 1'b0, 0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
